// File: rtl/axi_slv_pkg.sv
// Shared response encodings, channel FSM state types and the address-window helper
// for the AXI burst slave memory.
package axi_slv_pkg;

  localparam int BEAT_CNT_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Unsigned wrap of the subtraction makes addresses below the base fall out of window.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] win_bytes);
    logic [31:0] offset;
    offset = addr - base;
    return (offset < win_bytes);
  endfunction

endpackage

// File: rtl/axi_burst_slave_mem_if.sv
// AXI4 burst channel bundle between an initiator (master) and the slave memory.
interface axi_burst_slave_mem_if;

  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );

endinterface

// File: rtl/axi_slv_ram.sv
// Word-organised storage: one byte-enabled write port and one registered read port.
// Same-cycle read and write of one word returns the old contents.
module axi_slv_ram #(
  parameter int WORDS = 64,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_zero ? 32'h0000_0000 : mem_q[rd_idx];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 32'h0000_0000;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI4 INCR-burst slave backed by axi_slv_ram with independent read and write channels.
// Define AXI_SLV_WSTRB_EN to honour WSTRB byte lanes; otherwise every beat writes all 4 bytes.
module axi_burst_slave_mem
  import axi_slv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  axi_burst_slave_mem_if.slave  s_axi
);

  localparam int               IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0]      WIN_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  wr_state_e              w_state_q, w_state_d;
  logic                   awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic [IDX_W-1:0]       w_idx_q, w_idx_d;
  logic [BEAT_CNT_W-1:0]  w_beat_q, w_beat_d, w_len_q, w_len_d;
  logic                   w_decerr_q, w_decerr_d, w_slverr_q, w_slverr_d;

  rd_state_e              r_state_q, r_state_d;
  logic                   arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [IDX_W-1:0]       r_idx_q, r_idx_d;
  logic [BEAT_CNT_W-1:0]  r_beat_q, r_beat_d, r_len_q, r_len_d;
  logic                   r_decerr_q, r_decerr_d;

  logic                   ram_wr_en, ram_rd_en, ram_rd_zero;
  logic [3:0]             ram_wr_be;
  logic [IDX_W-1:0]       ram_rd_idx;
  logic [31:0]            ram_rd_data;
  logic                   w_is_last, w_last_bad, ar_in_win;

`ifdef AXI_SLV_WSTRB_EN
  assign ram_wr_be = s_axi.S_AXI_WSTRB;
`else
  assign ram_wr_be = s_axi.S_AXI_WSTRB | 4'hF;
`endif

  assign w_is_last  = (w_beat_q == w_len_q);
  assign w_last_bad = (s_axi.S_AXI_WLAST != w_is_last);
  assign ar_in_win  = addr_in_window(s_axi.S_AXI_ARADDR, BASE_ADDR, WIN_BYTES);

  // Write channel: beat count alone ends the burst; WLAST only grades the response.
  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_idx_d    = w_idx_q;
    w_beat_d   = w_beat_q;
    w_len_d    = w_len_q;
    w_decerr_d = w_decerr_q;
    w_slverr_d = w_slverr_q;
    ram_wr_en  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.S_AXI_AWVALID) begin
          w_state_d  = W_DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_idx_d    = s_axi.S_AXI_AWADDR[IDX_W+1:2];
          w_len_d    = s_axi.S_AXI_AWLEN;
          w_beat_d   = 8'd0;
          w_decerr_d = !addr_in_window(s_axi.S_AXI_AWADDR, BASE_ADDR, WIN_BYTES);
          w_slverr_d = 1'b0;
        end
      end
      W_DATA: begin
        if (s_axi.S_AXI_WVALID) begin
          ram_wr_en  = !w_decerr_q && !S_AXI_ARESET;
          w_idx_d    = w_idx_q + IDX_ONE;
          w_beat_d   = w_beat_q + 8'd1;
          w_slverr_d = w_slverr_q | w_last_bad;
          if (w_is_last) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_decerr_q ? RESP_DECERR :
                        (w_slverr_q || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read channel: the RAM register is the data pipeline, so the next word is only
  // fetched when the current beat is accepted and RDATA holds across stalls.
  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    r_idx_d     = r_idx_q;
    r_beat_d    = r_beat_q;
    r_len_d     = r_len_q;
    r_decerr_d  = r_decerr_q;
    ram_rd_en   = 1'b0;
    ram_rd_zero = r_decerr_q;
    ram_rd_idx  = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          r_state_d   = R_DATA;
          arready_d   = 1'b0;
          rvalid_d    = 1'b1;
          rlast_d     = (s_axi.S_AXI_ARLEN == 8'd0);
          rresp_d     = ar_in_win ? RESP_OKAY : RESP_DECERR;
          r_idx_d     = s_axi.S_AXI_ARADDR[IDX_W+1:2];
          r_beat_d    = 8'd0;
          r_len_d     = s_axi.S_AXI_ARLEN;
          r_decerr_d  = !ar_in_win;
          ram_rd_en   = 1'b1;
          ram_rd_zero = !ar_in_win;
          ram_rd_idx  = s_axi.S_AXI_ARADDR[IDX_W+1:2];
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_idx_d    = r_idx_q + IDX_ONE;
            r_beat_d   = r_beat_q + 8'd1;
            rlast_d    = ((r_beat_q + 8'd1) == r_len_q);
            ram_rd_en  = 1'b1;
            ram_rd_idx = r_idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Both channel FSMs; reset abandons any burst in flight without a response.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      w_idx_q    <= '0;
      w_beat_q   <= 8'd0;
      w_len_q    <= 8'd0;
      w_decerr_q <= 1'b0;
      w_slverr_q <= 1'b0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      r_idx_q    <= '0;
      r_beat_q   <= 8'd0;
      r_len_q    <= 8'd0;
      r_decerr_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      w_idx_q    <= w_idx_d;
      w_beat_q   <= w_beat_d;
      w_len_q    <= w_len_d;
      w_decerr_q <= w_decerr_d;
      w_slverr_q <= w_slverr_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      r_idx_q    <= r_idx_d;
      r_beat_q   <= r_beat_d;
      r_len_q    <= r_len_d;
      r_decerr_q <= r_decerr_d;
    end
  end

  axi_slv_ram #(.WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk     (S_AXI_ACLK),
    .rst     (S_AXI_ARESET),
    .wr_en   (ram_wr_en),
    .wr_idx  (w_idx_q),
    .wr_be   (ram_wr_be),
    .wr_data (s_axi.S_AXI_WDATA),
    .rd_en   (ram_rd_en),
    .rd_zero (ram_rd_zero),
    .rd_idx  (ram_rd_idx),
    .rd_data (ram_rd_data)
  );

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = ram_rd_data;

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed bench for axi_burst_slave_mem: bursts, stalls, window errors, WLAST errors,
// byte strobes, mid-burst reset and 256-beat wrap; inputs driven and outputs sampled on negedge.
module tb_axi_burst_slave_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wr_buf  [256];
  logic [31:0] exp_buf [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [1:0]  bresp_got;
  logic [31:0] strb_exp;

  axi_burst_slave_mem_if bus();

  axi_burst_slave_mem #(.BASE_ADDR(32'h2000_0000), .MEM_WORDS(64)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input int wlast_beat, input logic [3:0] strb,
                             output logic [1:0] resp);
    int n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWLEN   = len;
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
    check("awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WDATA  = wr_buf[b];
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_WLAST  = (b == wlast_beat);
      n = 0;
      while (!bus.S_AXI_WREADY && n < 50) begin @(negedge clk); n++; end
      check("wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
      @(negedge clk);
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    check("bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    resp = bus.S_AXI_BRESP;
    @(negedge clk);
    check("bvalid_hold", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    check("bresp_hold", {30'd0, bus.S_AXI_BRESP}, {30'd0, resp});
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_drop", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    check("awready_back", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
    int n;
    int got;
    int cyc;
    bit stalled;
    logic [31:0] hold_data;
    logic        hold_last;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = len;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    check("arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    check("rvalid_latency", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    hold_data = 32'd0;
    hold_last = 1'b0;
    while (got <= int'(len) && cyc < 2000) begin
      bus.S_AXI_RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      if (stalled) begin
        check("rdata_stable", bus.S_AXI_RDATA, hold_data);
        check("rlast_stable", {31'd0, bus.S_AXI_RLAST}, {31'd0, hold_last});
      end
      stalled = 1'b0;
      if (bus.S_AXI_RVALID) begin
        if (bus.S_AXI_RREADY) begin
          rd_data[got] = bus.S_AXI_RDATA;
          rd_resp[got] = bus.S_AXI_RRESP;
          rd_last[got] = bus.S_AXI_RLAST;
          got++;
        end else begin
          stalled   = 1'b1;
          hold_data = bus.S_AXI_RDATA;
          hold_last = bus.S_AXI_RLAST;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.S_AXI_RREADY = 1'b0;
    check("r_beats", got, int'(len) + 1);
    check("rvalid_end", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    check("arready_end", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
  endtask

  task automatic verify_read(input string tag, input int len, input logic [1:0] resp);
    for (int i = 0; i <= len; i++) begin
      check($sformatf("%s_data%0d", tag, i), rd_data[i], exp_buf[i]);
      check($sformatf("%s_resp%0d", tag, i), {30'd0, rd_resp[i]}, {30'd0, resp});
      check($sformatf("%s_last%0d", tag, i), {31'd0, rd_last[i]}, {31'd0, (i == len)});
    end
  endtask

  initial begin
    bus.S_AXI_AWADDR = 32'd0; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = 32'd0; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = 32'd0; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    check("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
    check("rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    check("rst_rlast", {31'd0, bus.S_AXI_RLAST}, 32'd0);
    check("rst_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
    check("rst_rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 16-beat write and read-back
    for (int i = 0; i < 16; i++) wr_buf[i] = 32'(i * 3 + 1);
    write_burst(32'h2000_0000, 8'd15, 15, 4'hF, bresp_got);
    check("b16_resp", {30'd0, bresp_got}, 32'd0);
    for (int i = 0; i < 16; i++) exp_buf[i] = 32'(i * 3 + 1);
    read_burst(32'h2000_0000, 8'd15, 1'b0);
    verify_read("r16", 15, 2'b00);

    // Same read with RREADY toggling
    read_burst(32'h2000_0000, 8'd15, 1'b1);
    verify_read("r16tog", 15, 2'b00);

    // Out-of-window write dropped, out-of-window read returns zeros
    for (int i = 0; i < 4; i++) wr_buf[i] = 32'hDEAD_0000 + 32'(i);
    write_burst(32'h1000_0000, 8'd3, 3, 4'hF, bresp_got);
    check("dec_wresp", {30'd0, bresp_got}, 32'd3);
    for (int i = 0; i < 4; i++) exp_buf[i] = 32'(i * 3 + 1);
    read_burst(32'h2000_0000, 8'd3, 1'b0);
    verify_read("unchanged", 3, 2'b00);
    for (int i = 0; i < 4; i++) exp_buf[i] = 32'd0;
    read_burst(32'h1000_0000, 8'd3, 1'b0);
    verify_read("dec_rd", 3, 2'b11);

    // Early WLAST and missing WLAST both grade SLVERR
    for (int i = 0; i < 4; i++) wr_buf[i] = 32'h0000_0700 + 32'(i);
    write_burst(32'h2000_0040, 8'd3, 1, 4'hF, bresp_got);
    check("early_wlast", {30'd0, bresp_got}, 32'd2);
    write_burst(32'h2000_0040, 8'd1, -1, 4'hF, bresp_got);
    check("no_wlast", {30'd0, bresp_got}, 32'd2);

    // Byte-strobe write
    wr_buf[0] = 32'h1122_3344;
    write_burst(32'h2000_0080, 8'd0, 0, 4'hF, bresp_got);
    wr_buf[0] = 32'hAABB_CCDD;
    write_burst(32'h2000_0080, 8'd0, 0, 4'b0001, bresp_got);
    check("strb_resp", {30'd0, bresp_got}, 32'd0);
`ifdef AXI_SLV_WSTRB_EN
    strb_exp = 32'h1122_33DD;
`else
    strb_exp = 32'hAABB_CCDD;
`endif
    exp_buf[0] = strb_exp;
    read_burst(32'h2000_0080, 8'd0, 1'b0);
    verify_read("strb", 0, 2'b00);

    // Reset during beat 5 of a 16-beat write over pre-filled words 48..63
    for (int i = 0; i < 16; i++) wr_buf[i] = 32'h0000_0500 + 32'(i);
    write_burst(32'h2000_00C0, 8'd15, 15, 4'hF, bresp_got);
    bus.S_AXI_AWADDR  = 32'h2000_00C0;
    bus.S_AXI_AWLEN   = 8'd15;
    bus.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    check("abort_wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
    for (int b = 0; b < 5; b++) begin
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WDATA  = 32'h0000_0100 + 32'(b);
      @(negedge clk);
    end
    bus.S_AXI_WDATA = 32'h0000_0105;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    check("abort_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    check("abort_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    check("abort_wready_off", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_bvalid_late", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    for (int i = 0; i < 5; i++) exp_buf[i] = 32'h0000_0100 + 32'(i);
    exp_buf[5] = 32'h0000_0505;
    read_burst(32'h2000_00C0, 8'd5, 1'b0);
    verify_read("abort", 5, 2'b00);

    // 256-beat write from word 60 wraps the 64-word store four times
    for (int i = 0; i < 256; i++) wr_buf[i] = 32'h0000_1000 + 32'(i);
    write_burst(32'h2000_00F0, 8'd255, 255, 4'hF, bresp_got);
    check("wrap_resp", {30'd0, bresp_got}, 32'd0);
    for (int b = 0; b < 256; b++) exp_buf[b] = 32'h0000_1000 + 32'(((b + 4) % 64) + 192);
    read_burst(32'h2000_0000, 8'd255, 1'b0);
    verify_read("wrap", 255, 2'b00);

    // Window edges
    exp_buf[0] = 32'h0000_10C3;
    read_burst(32'h2000_00FC, 8'd0, 1'b0);
    verify_read("edge_hi", 0, 2'b00);
    exp_buf[0] = 32'd0;
    read_burst(32'h2000_0100, 8'd0, 1'b0);
    verify_read("edge_above", 0, 2'b11);
    read_burst(32'h1FFF_FFFC, 8'd0, 1'b0);
    verify_read("edge_below", 0, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_burst_slave_mem.md
AXI_BURST_SLAVE_MEM -- requirements
Module: axi_burst_slave_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h20000000, the byte base of the decoded window.
REQ-002 SHALL have parameter MEM_WORDS, default 64, the number of 32-bit storage words (power of 2, 16..1024).
REQ-003 S_AXI_ACLK  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 S_AXI_ARESET  in  1  synchronous, active-high reset.
REQ-005 S_AXI_AWADDR  in  32  write burst start byte address.
REQ-006 S_AXI_AWLEN  in  8  write beats minus 1.
REQ-007 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write address handshake.
REQ-008 S_AXI_WDATA  in  32  write beat data.
REQ-009 S_AXI_WSTRB  in  4  byte-lane enables.
REQ-010 S_AXI_WLAST  in  1  initiator's last-beat marker.
REQ-011 S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write data handshake.
REQ-012 S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR, 11 DECERR).
REQ-013 S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write response handshake.
REQ-014 S_AXI_ARADDR  in  32  read burst start byte address.
REQ-015 S_AXI_ARLEN  in  8  read beats minus 1.
REQ-016 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read address handshake.
REQ-017 S_AXI_RDATA / S_AXI_RRESP / S_AXI_RLAST  out  32 / 2 / 1  read beat data, response, last marker.
REQ-018 S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read data handshake.

Function
REQ-019 Bursts SHALL be INCR only, 4-byte beats; word index = (start_addr[..:2] + beat) mod MEM_WORDS; address bits [1:0] ignored.
REQ-020 A burst SHALL be in-window when (start_addr - BASE_ADDR) < 4*MEM_WORDS; otherwise writes are dropped and the response is DECERR.
REQ-021 Write FSM W_IDLE -> W_DATA on AW handshake; W_DATA -> W_RESP on the (AWLEN+1)th W handshake; W_RESP -> W_IDLE on B handshake.
REQ-022 AWREADY SHALL be 1 only in W_IDLE; WREADY only in W_DATA; BVALID only in W_RESP, held with BRESP stable until BREADY.
REQ-023 Each accepted beat SHALL update memory in the same clock edge.
REQ-024 WLAST asserted before the final beat, or deasserted on it, SHALL yield SLVERR (DECERR takes precedence); beat count alone ends the burst.
REQ-025 Read FSM R_IDLE -> R_DATA on AR handshake; ARREADY = 1 only in R_IDLE.
REQ-026 First RVALID SHALL assert the cycle after the AR handshake (1-cycle latency); subsequent beats one per cycle while RREADY=1.
REQ-027 RDATA/RRESP/RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-028 RLAST SHALL be 1 on beat ARLEN+1 only; the R handshake on it returns to R_IDLE, ARREADY rising the next cycle.
REQ-029 Out-of-window reads SHALL return RDATA=0 and RRESP=DECERR on every beat, with full beat count.
REQ-030 Read and write channels SHALL run concurrently; a read beat fetched in the same cycle as a write to the same word SHALL return the pre-write value.
REQ-031 Beat counters SHALL be 8 bits; AWLEN/ARLEN=255 SHALL complete 256 beats with index wrap at MEM_WORDS.

Reset
REQ-032 On S_AXI_ARESET both FSMs SHALL go idle; AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=RRESP=00, RDATA=0.
REQ-033 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL NOT be reset.

Configuration
REQ-034 With AXI_SLV_WSTRB_EN defined, only byte lanes with WSTRB=1 SHALL be written; without it, WSTRB is ignored and all 4 bytes are written.

Structure
REQ-035 Package axi_slv_pkg SHALL hold the response encodings (OKAY/SLVERR/DECERR), the write-FSM and read-FSM state typedefs, and beat-counter width.
REQ-036 Storage SHALL be one sub-module axi_slv_ram (1 write port with byte enables, 1 registered read port).

Verification
REQ-037 AW 0x20000000 len 15, data i*3+1 (i=0..15), WLAST on beat 15 -> BRESP OKAY; AR same -> 16 beats 1,4,...,46, RLAST on 16th.
REQ-038 Read burst with RREADY toggling every cycle -> no lost or duplicated beats, RDATA stable while stalled.
REQ-039 AW 0x10000000 len 3 -> BRESP DECERR, memory unchanged; AR 0x10000000 len 3 -> 4 beats RDATA 0, RRESP DECERR.
REQ-040 Write len 3 with WLAST on beat 1 -> 4 beats accepted, BRESP SLVERR.
REQ-041 WSTRB=0001 write of 0xAABBCCDD over 0x11223344 -> with AXI_SLV_WSTRB_EN reads 0x112233DD; without, reads 0xAABBCCDD.
REQ-042 Reset asserted at write beat 5 of 16 -> BVALID stays 0, AWREADY=1 next cycle; beats 0..4 retained in memory.
